stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter FRQ, default 24000000, system clock frequency in Hz; PRE = FRQ/1000 clock cycles per millisecond tick; FRQ SHALL be a multiple of 1000 and FRQ/1000 >= 2.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 b_run  input  1  debounced run/stop button level, active high.
REQ-005 b_clr  input  1  debounced clear button level, active high.
REQ-006 b_tmp  input  1  debounced lap (temporary hold) button level, active high.
REQ-007 s_run  output  1  high while the time counter is counting.
REQ-008 s_hld  output  1  high while the displayed time is frozen (lap).
REQ-009 t_mil_0, t_mil_1, t_mil_2  output  4 each  displayed milliseconds in BCD: units, tens, hundreds.
REQ-010 t_sec_0, t_sec_1  output  4 each  displayed seconds in BCD: units (0-9), tens (0-5).
REQ-011 t_min_0, t_min_1  output  4 each  displayed minutes in BCD: units (0-9), tens (0-5).

Function
REQ-012 Each button input SHALL be registered once; a press event is a cycle in which the input is 1 and its registered copy is 0; a held level SHALL produce exactly one event.
REQ-013 The FSM SHALL have three states: STOP, RUN and LAP.
REQ-014 In STOP: a run event moves to RUN; a clr event clears the prescaler and all seven time digits and stays in STOP; a tmp event is ignored.
REQ-015 In RUN: a run event moves to STOP; a tmp event loads the lap latch with the live time and moves to LAP; a clr event is ignored.
REQ-016 In LAP: a tmp event moves to RUN; a run event moves to STOP; a clr event is ignored.
REQ-017 Simultaneous events in one cycle SHALL be prioritised run > tmp > clr; only the highest-priority applicable event acts.
REQ-018 The state and the s_run/s_hld outputs SHALL update on the same clock edge at which the event is detected; s_run = (RUN or LAP), s_hld = LAP.
REQ-019 The prescaler SHALL count 0..PRE-1 only in RUN and LAP; in STOP it holds its value.
REQ-020 A tick SHALL occur when the prescaler equals PRE-1 in a counting state; the prescaler then returns to 0.
REQ-021 On a tick the time SHALL advance by 1 ms as a BCD cascade: each digit carries to the next at 9 (t_sec_1 and t_min_1 carry at 5).
REQ-022 At 59:59.999 a tick SHALL wrap all seven digits to 0 with no other effect (no flag, counting continues).
REQ-023 t_* outputs SHALL be registered: the lap latch in LAP, otherwise the live time, each value appearing one cycle after it is formed.
REQ-024 Leaving LAP (to RUN or STOP) SHALL switch the outputs back to the live time on the following cycle; lap latch content is don't-care outside LAP.
REQ-025 A tick and a state-changing event in the same cycle: the tick SHALL be applied (time advances) and the new state takes effect from the next cycle.

Reset
REQ-026 While reset_n = 0: state STOP, prescaler 0, all live, latch and output digits 0, s_run = 0, s_hld = 0, button registers 0.
REQ-027 A button held high through reset release SHALL produce one event on the first clock edge after release.
REQ-028 Reset asserted mid-count SHALL clear all state asynchronously, with no pending event surviving reset.

Verification
REQ-029 Run FRQ=4000 (PRE=4); reset, single run press, 40 cycles: s_run=1 one edge after press; t_mil_0 reaches 9, then t_mil_1=1, t_mil_0=0 on 10th tick.
REQ-030 Run, then a tmp press at t=00:00.003, 20 more cycles: s_hld=1 and outputs stay 00:00.003; second tmp press: outputs track live time (>= 00:00.008) one cycle later.
REQ-031 Preload/force live time 59:59.998, run 8 cycles: outputs show 59:59.999 then 00:00.000; s_run stays 1.
REQ-032 Same-cycle run+tmp+clr in RUN: state goes to STOP, s_hld=0, time not cleared; then a clr in STOP: all digits 0 next cycle.
REQ-033 clr press in RUN and in LAP: no change to time or state; b_run held high for 100 cycles: exactly one toggle.
REQ-034 reset_n low for 1 cycle mid-count at 00:01.234: all outputs 0 immediately, s_run=0; b_run held through release: RUN on first edge after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
//   Millisecond stopwatch controller with run/stop, clear and lap (temporary
//   hold) buttons. A prescaler divides the system clock into 1 ms ticks that
//   drive a seven-digit BCD time counter (mm:ss.mmm, wraps at 59:59.999).
//   A three-state FSM (STOP / RUN / LAP) reacts to rising edges of the
//   debounced button levels; in LAP the display is frozen on a latched copy
//   of the time while the live counter keeps running underneath.
//
// Parameters
//   FRQ      system clock in Hz; must be a multiple of 1000, FRQ/1000 >= 2
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   b_run    in   run/stop button level (active high)
//   b_clr    in   clear button level (active high)
//   b_tmp    in   lap button level (active high)
//   s_run    out  counter is counting (RUN or LAP)
//   s_hld    out  display frozen (LAP)
//   t_mil_0..2, t_sec_0..1, t_min_0..1  out  registered BCD display digits
// ----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned FRQ = 24000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       b_run,
    input  logic       b_clr,
    input  logic       b_tmp,
    output logic       s_run,
    output logic       s_hld,
    output logic [3:0] t_mil_0,
    output logic [3:0] t_mil_1,
    output logic [3:0] t_mil_2,
    output logic [3:0] t_sec_0,
    output logic [3:0] t_sec_1,
    output logic [3:0] t_min_0,
    output logic [3:0] t_min_1
);

    localparam int unsigned     PRE      = FRQ / 1000;
    localparam int unsigned     PW       = $clog2(PRE);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRE - 1);

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAP  = 2'd2;

    // Time vectors are packed {min_1, min_0, sec_1, sec_0, mil_2, mil_1, mil_0},
    // one BCD nibble per digit, least significant digit in bits [3:0].
    logic          run_q, clr_q, tmp_q;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [27:0]   live_q, live_d;
    logic [27:0]   lap_q, lap_d;
    logic [27:0]   disp_q, disp_d;

    logic ev_run, ev_clr, ev_tmp;
    logic counting, tick, clear, load_lap;

    // One-millisecond BCD increment. Digit 4 (seconds tens) and digit 6
    // (minutes tens) roll over at 5, all others at 9; a carry out of the top
    // digit is simply dropped, which gives the 59:59.999 -> 00:00.000 wrap.
    function automatic logic [27:0] bcd_inc(input logic [27:0] t);
        logic [27:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lim = (i == 4 || i == 6) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Press events: input high while its one-cycle-old copy is still low.
    assign ev_run = b_run & ~run_q;
    assign ev_clr = b_clr & ~clr_q;
    assign ev_tmp = b_tmp & ~tmp_q;

    assign counting = (state_q != ST_STOP);
    assign tick     = counting && (pre_q == PRE_LAST);

    // Event arbitration: run beats tmp beats clr; an event that has no
    // meaning in the current state does not block a lower-priority one.
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        load_lap = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (ev_run) begin
                    state_d = ST_RUN;
                end else if (ev_clr) begin
                    clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (ev_run) begin
                    state_d = ST_STOP;
                end else if (ev_tmp) begin
                    state_d  = ST_LAP;
                    load_lap = 1'b1;
                end
            end
            ST_LAP: begin
                if (ev_run) begin
                    state_d = ST_STOP;
                end else if (ev_tmp) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Datapath next-state. The tick is judged on the current state, so a tick
    // coinciding with a stop event still advances the time.
    always_comb begin
        pre_d  = pre_q;
        live_d = live_q;
        if (clear) begin
            pre_d  = '0;
            live_d = '0;
        end else if (counting) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                live_d = bcd_inc(live_q);
            end
        end
        lap_d  = load_lap ? live_q : lap_q;
        // Display follows the state one cycle behind: a freshly latched lap
        // value, or the live time after leaving LAP, shows on the next edge.
        disp_d = (state_q == ST_LAP) ? lap_q : live_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            tmp_q   <= 1'b0;
            state_q <= ST_STOP;
            pre_q   <= '0;
            live_q  <= '0;
            lap_q   <= '0;
            disp_q  <= '0;
        end else begin
            run_q   <= b_run;
            clr_q   <= b_clr;
            tmp_q   <= b_tmp;
            state_q <= state_d;
            pre_q   <= pre_d;
            live_q  <= live_d;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
        end
    end

    assign s_run   = (state_q != ST_STOP);
    assign s_hld   = (state_q == ST_LAP);

    assign t_mil_0 = disp_q[3:0];
    assign t_mil_1 = disp_q[7:4];
    assign t_mil_2 = disp_q[11:8];
    assign t_sec_0 = disp_q[15:12];
    assign t_sec_1 = disp_q[19:16];
    assign t_min_0 = disp_q[23:20];
    assign t_min_1 = disp_q[27:24];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int FRQ = 4000;
    localparam int PRE = FRQ / 1000;
    localparam int WRAP_MS = 60 * 60 * 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic b_run = 1'b0;
    logic b_clr = 1'b0;
    logic b_tmp = 1'b0;
    logic s_run, s_hld;
    logic [3:0] t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1;
    logic [27:0] dut_t;

    int checks = 0;
    int failures = 0;

    // Reference model: time held as a plain millisecond count.
    // m_st: 0 = stopped, 1 = running, 2 = lap hold
    int m_st, m_pre, m_t, m_lap, m_out;
    bit m_pr, m_pc, m_pt;

    stopwatch_ctrl #(.FRQ(FRQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .b_run   (b_run),
        .b_clr   (b_clr),
        .b_tmp   (b_tmp),
        .s_run   (s_run),
        .s_hld   (s_hld),
        .t_mil_0 (t_mil_0),
        .t_mil_1 (t_mil_1),
        .t_mil_2 (t_mil_2),
        .t_sec_0 (t_sec_0),
        .t_sec_1 (t_sec_1),
        .t_min_0 (t_min_0),
        .t_min_1 (t_min_1)
    );

    always #5 clk = ~clk;

    assign dut_t = {t_min_1, t_min_0, t_sec_1, t_sec_0, t_mil_2, t_mil_1, t_mil_0};

    function automatic logic [27:0] to_bcd(input int ms);
        int mil, sec, mn;
        mil = ms % 1000;
        sec = (ms / 1000) % 60;
        mn  = ms / 60000;
        return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10),
                4'(mil / 100), 4'((mil / 10) % 10), 4'(mil % 10)};
    endfunction

    function logic [29:0] exp_vec();
        return {(m_st != 0), (m_st == 2), to_bcd(m_out)};
    endfunction

    task model_reset();
        m_st = 0; m_pre = 0; m_t = 0; m_lap = 0; m_out = 0;
        m_pr = 0; m_pc = 0; m_pt = 0;
    endtask

    // Advance DUT and model by one clock edge; returns #1 after the edge.
    task cycle();
        bit er, ec, et, tick, clr;
        int nst, nt, npre, nlap, nout;
        er = b_run && !m_pr;
        ec = b_clr && !m_pc;
        et = b_tmp && !m_pt;
        tick = (m_st != 0) && (m_pre == PRE - 1);
        nst = m_st; nlap = m_lap; clr = 0;
        if (er)                     nst = (m_st == 0) ? 1 : 0;
        else if (et && m_st == 1) begin nst = 2; nlap = m_t; end
        else if (et && m_st == 2)   nst = 1;
        else if (ec && m_st == 0)   clr = 1;
        nout = (m_st == 2) ? m_lap : m_t;
        nt   = clr ? 0 : (tick ? (m_t + 1) % WRAP_MS : m_t);
        npre = clr ? 0 : ((m_st != 0) ? (tick ? 0 : m_pre + 1) : m_pre);
        @(posedge clk);
        #1;
        m_st = nst; m_t = nt; m_pre = npre; m_lap = nlap; m_out = nout;
        m_pr = b_run; m_pc = b_clr; m_pt = b_tmp;
    endtask

    task do_reset();
        b_run = 0; b_clr = 0; b_tmp = 0;
        reset_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task test_reset();
        #2 reset_n = 0;
        #1;
        model_reset();
        checks++;
        if (dut_t !== 28'h0) begin
            failures++; $display("FAIL reset_time got=%h exp=%h", dut_t, 28'h0);
        end
        checks++;
        if (s_run !== 1'b0) begin
            failures++; $display("FAIL reset_s_run got=%b exp=0", s_run);
        end
        checks++;
        if (s_hld !== 1'b0) begin
            failures++; $display("FAIL reset_s_hld got=%b exp=0", s_hld);
        end
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task test_run_count();
        do_reset();
        b_run = 1;
        cycle();
        b_run = 0;
        checks++;
        if (s_run !== 1'b1) begin
            failures++; $display("FAIL run_press_s_run got=%b exp=1", s_run);
        end
        for (int n = 1; n <= 41; n++) begin
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec()) begin
                failures++;
                $display("FAIL run_count cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
            if (n == 37) begin
                checks++;
                if (t_mil_0 !== 4'd9) begin
                    failures++; $display("FAIL run_mil0_nine got=%0d exp=9", t_mil_0);
                end
            end
        end
        checks++;
        if (dut_t !== 28'h0000010) begin
            failures++; $display("FAIL run_tenth_tick got=%h exp=%h", dut_t, 28'h0000010);
        end
    endtask

    task test_lap();
        do_reset();
        b_run = 1;
        cycle();
        b_run = 0;
        for (int n = 0; n < 100 && m_t != 3; n++) cycle();
        b_tmp = 1;
        cycle();
        b_tmp = 0;
        checks++;
        if (s_hld !== 1'b1) begin
            failures++; $display("FAIL lap_enter_s_hld got=%b exp=1", s_hld);
        end
        for (int n = 0; n < 20; n++) begin
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== {2'b11, 28'h0000003}) begin
                failures++;
                $display("FAIL lap_frozen cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, {2'b11, 28'h0000003});
            end
        end
        b_tmp = 1;
        cycle();
        b_tmp = 0;
        checks++;
        if ({s_run, s_hld, dut_t} !== exp_vec()) begin
            failures++; $display("FAIL lap_leave got=%h exp=%h", {s_run, s_hld, dut_t}, exp_vec());
        end
        cycle();
        checks++;
        if ({s_run, s_hld, dut_t} !== exp_vec() || dut_t < 28'h0000008) begin
            failures++; $display("FAIL lap_track got=%h exp=%h (>=8ms)", {s_run, s_hld, dut_t}, exp_vec());
        end
    endtask

    task test_wrap();
        do_reset();
        force dut.live_q = 28'h5959998;
        m_t = 59 * 60000 + 59 * 1000 + 998;
        cycle();
        release dut.live_q;
        b_run = 1;
        cycle();
        b_run = 0;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_track cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
            if (n == 5) begin
                checks++;
                if (dut_t !== 28'h5959999) begin
                    failures++; $display("FAIL wrap_last got=%h exp=%h", dut_t, 28'h5959999);
                end
            end
            if (n == 9) begin
                checks++;
                if ({s_run, dut_t} !== {1'b1, 28'h0}) begin
                    failures++; $display("FAIL wrap_zero got=%h exp=%h", {s_run, dut_t}, {1'b1, 28'h0});
                end
            end
        end
    endtask

    task test_priority();
        do_reset();
        b_run = 1;
        cycle();
        b_run = 0;
        for (int n = 0; n < 10; n++) cycle();
        b_run = 1; b_tmp = 1; b_clr = 1;
        cycle();
        b_run = 0; b_tmp = 0; b_clr = 0;
        checks++;
        if ({s_run, s_hld} !== 2'b00) begin
            failures++; $display("FAIL prio_state got=%b exp=00", {s_run, s_hld});
        end
        cycle();
        checks++;
        if ({s_run, s_hld, dut_t} !== {2'b00, 28'h0000002}) begin
            failures++; $display("FAIL prio_not_cleared got=%h exp=%h", {s_run, s_hld, dut_t}, {2'b00, 28'h0000002});
        end
        b_clr = 1;
        cycle();
        b_clr = 0;
        cycle();
        checks++;
        if ({s_run, s_hld, dut_t} !== 30'h0) begin
            failures++; $display("FAIL stop_clear got=%h exp=%h", {s_run, s_hld, dut_t}, 30'h0);
        end
        // run+tmp together while in LAP must also stop
        b_run = 1;
        cycle();
        b_run = 0;
        b_tmp = 1;
        cycle();
        b_tmp = 0;
        cycle();
        b_run = 1; b_tmp = 1;
        cycle();
        b_run = 0; b_tmp = 0;
        checks++;
        if ({s_run, s_hld} !== 2'b00 || {s_run, s_hld, dut_t} !== exp_vec()) begin
            failures++; $display("FAIL prio_lap_stop got=%h exp=%h", {s_run, s_hld, dut_t}, exp_vec());
        end
    endtask

    task test_clr_ignored();
        int toggles;
        logic prev;
        do_reset();
        b_run = 1;
        cycle();
        b_run = 0;
        for (int n = 0; n < 6; n++) cycle();
        b_clr = 1;
        cycle();
        b_clr = 0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec() || s_run !== 1'b1) begin
                failures++;
                $display("FAIL clr_in_run cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
        end
        b_tmp = 1;
        cycle();
        b_tmp = 0;
        b_clr = 1;
        cycle();
        b_clr = 0;
        cycle();
        checks++;
        if ({s_run, s_hld, dut_t} !== exp_vec() || s_hld !== 1'b1) begin
            failures++; $display("FAIL clr_in_lap got=%h exp=%h", {s_run, s_hld, dut_t}, exp_vec());
        end
        toggles = 0;
        prev = s_run;
        b_run = 1;
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (s_run !== prev) toggles++;
            prev = s_run;
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec()) begin
                failures++;
                $display("FAIL run_held cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
        end
        b_run = 0;
        checks++;
        if (toggles != 1) begin
            failures++; $display("FAIL run_held_toggles got=%0d exp=1", toggles);
        end
    endtask

    task test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            b_run = ($urandom_range(0, 24) == 0);
            b_tmp = ($urandom_range(0, 9) < 2);
            b_clr = ($urandom_range(0, 14) == 0);
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
        end
        b_run = 0; b_tmp = 0; b_clr = 0;
    endtask

    task test_reset_midcount();
        do_reset();
        b_run = 1;
        cycle();
        b_run = 0;
        for (int n = 0; n < 6000 && m_t != 1234; n++) cycle();
        checks++;
        if (m_t != 1234 || dut.live_q !== 28'h0001234) begin
            failures++; $display("FAIL midcount_reach live=%h exp=%h", dut.live_q, 28'h0001234);
        end
        reset_n = 0;
        b_run = 1;
        #1;
        model_reset();
        checks++;
        if ({s_run, s_hld, dut_t} !== 30'h0) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", {s_run, s_hld, dut_t}, 30'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({s_run, s_hld, dut_t} !== 30'h0) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", {s_run, s_hld, dut_t}, 30'h0);
        end
        reset_n = 1;
        cycle();
        checks++;
        if (s_run !== 1'b1) begin
            failures++; $display("FAIL release_run got=%b exp=1", s_run);
        end
        for (int n = 0; n < 8; n++) begin
            cycle();
            checks++;
            if ({s_run, s_hld, dut_t} !== exp_vec()) begin
                failures++;
                $display("FAIL after_release cyc=%0d got=%h exp=%h", n, {s_run, s_hld, dut_t}, exp_vec());
            end
        end
        b_run = 0;
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_lap();
        test_wrap();
        test_priority();
        test_clr_ignored();
        test_random();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
